// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 datapath pack stage.
package fma16_pkg;

  typedef enum logic [1:0] {
    RM_RZ  = 2'b00,
    RM_RNE = 2'b01,
    RM_RD  = 2'b10,
    RM_RU  = 2'b11
  } roundmode_t;

  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam logic [15:0] QNAN_H    = 16'h7E00;
  localparam logic [14:0] MAXNORM_H = 15'h7BFF;
  localparam int          EXP_MAX   = 31;

endpackage

// File: rtl/fma16_pack_special.sv
// Combinational result selection: special cases, overflow direction,
// underflow flush and normal packing of a half-precision value.
module fma16_pack_special
  import fma16_pkg::*;
#(
  parameter int          EXP_W = 8,
  parameter logic [15:0] QNAN  = QNAN_H
) (
  input  logic             ms,
  input  logic [EXP_W-1:0] me,
  input  logic [9:0]       mm_rounded,
  input  logic             round_carry,
  input  logic             nx_bits,
  input  logic [1:0]       roundmode,
  input  logic             is_nan,
  input  logic             is_inf,
  input  logic             is_zero,
  input  logic             inv,
  output logic [15:0]      result,
  output logic [3:0]       flags
);

  localparam logic signed [EXP_W:0] E_OVF = (EXP_W+1)'(EXP_MAX);

  logic signed [EXP_W:0] e;
  logic                  overflow;
  logic                  underflow;
  logic                  ovf_to_inf;
  roundmode_t            rm;

  // One extra bit keeps me + carry from wrapping before the range checks.
  assign e         = $signed({me[EXP_W-1], me}) + $signed({{EXP_W{1'b0}}, round_carry});
  assign overflow  = (e >= E_OVF);
  assign underflow = e[EXP_W] || (e == '0);
  assign rm        = roundmode_t'(roundmode);

  // Overflow saturates to infinity only when rounding away from zero.
  assign ovf_to_inf = (rm == RM_RNE) || (rm == RM_RU && !ms) || (rm == RM_RD && ms);

  always_comb begin
    result = {ms, e[4:0], mm_rounded};
    flags  = '0;
    flags[FLG_NX] = nx_bits;
    if (is_nan || inv) begin
      result = QNAN;
      flags  = '0;
      flags[FLG_NV] = inv;
    end else if (is_inf) begin
      result = {ms, 5'h1F, 10'h000};
      flags  = '0;
    end else if (is_zero) begin
      result = {ms, 15'h0000};
      flags  = '0;
    end else if (overflow) begin
      result = ovf_to_inf ? {ms, 5'h1F, 10'h000} : {ms, MAXNORM_H};
      flags  = '0;
      flags[FLG_OF] = 1'b1;
      flags[FLG_NX] = 1'b1;
    end else if (underflow) begin
      result = {ms, 15'h0000};
      flags  = '0;
      flags[FLG_UF] = 1'b1;
      flags[FLG_NX] = 1'b1;
    end
  end

endmodule

// File: rtl/fma16_pack.sv
// Final fma16 stage: registers the packed half-precision result and flags
// behind valid/ready. Define FMA16_STICKY_FLAGS_EN for a sticky flag accumulator.
module fma16_pack
  import fma16_pkg::*;
#(
  parameter int          EXP_W = 8,
  parameter logic [15:0] QNAN  = 16'h7E00
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ms,
  input  logic [EXP_W-1:0] me,
  input  logic [9:0]       mm_rounded,
  input  logic             round_carry,
  input  logic             nx_bits,
  input  logic [1:0]       roundmode,
  input  logic             is_nan,
  input  logic             is_inf,
  input  logic             is_zero,
  input  logic             inv,
  output logic [15:0]      result,
  output logic [3:0]       flags,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FMA16_STICKY_FLAGS_EN
  ,
  input  logic             flag_clr,
  output logic [3:0]       sticky_flags
`endif
);

  logic [15:0] next_result;
  logic [3:0]  next_flags;
  logic        in_xfer;

  fma16_pack_special #(
    .EXP_W (EXP_W),
    .QNAN  (QNAN)
  ) u_special (
    .ms          (ms),
    .me          (me),
    .mm_rounded  (mm_rounded),
    .round_carry (round_carry),
    .nx_bits     (nx_bits),
    .roundmode   (roundmode),
    .is_nan      (is_nan),
    .is_inf      (is_inf),
    .is_zero     (is_zero),
    .inv         (inv),
    .result      (next_result),
    .flags       (next_flags)
  );

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else if (in_xfer) begin
      result    <= next_result;
      flags     <= next_flags;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FMA16_STICKY_FLAGS_EN
  // Clear takes priority over accumulating the flags being popped this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_flags <= '0;
    end else if (flag_clr) begin
      sticky_flags <= '0;
    end else if (out_valid && out_ready) begin
      sticky_flags <= sticky_flags | flags;
    end
  end
`endif

endmodule

// File: tb/tb_fma16_pack.sv
// Directed self-checking bench for fma16_pack; sticky-flag vectors run only
// when FMA16_STICKY_FLAGS_EN is defined.
module tb_fma16_pack;
  import fma16_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        ms;
  logic [7:0]  me;
  logic [9:0]  mm_rounded;
  logic        round_carry;
  logic        nx_bits;
  logic [1:0]  roundmode;
  logic        is_nan;
  logic        is_inf;
  logic        is_zero;
  logic        inv;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        out_valid;
  logic        out_ready;
`ifdef FMA16_STICKY_FLAGS_EN
  logic        flag_clr;
  logic [3:0]  sticky_flags;
`endif

  int check_count = 0;
  int error_count = 0;

  fma16_pack #(
    .EXP_W (8),
    .QNAN  (16'h7E00)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ms           (ms),
    .me           (me),
    .mm_rounded   (mm_rounded),
    .round_carry  (round_carry),
    .nx_bits      (nx_bits),
    .roundmode    (roundmode),
    .is_nan       (is_nan),
    .is_inf       (is_inf),
    .is_zero      (is_zero),
    .inv          (inv),
    .result       (result),
    .flags        (flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
`ifdef FMA16_STICKY_FLAGS_EN
    ,
    .flag_clr     (flag_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] expected);
    check_count++;
    if (got !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, expected);
    end
  endtask

  // Drive one operand on a falling edge, without changing the handshake lines.
  task automatic setOperand(input logic s, input logic [7:0] e, input logic [9:0] m,
                            input logic c, input logic nx, input logic [1:0] rm,
                            input logic nan, input logic inf, input logic zero, input logic iv);
    ms = s; me = e; mm_rounded = m; round_carry = c; nx_bits = nx; roundmode = rm;
    is_nan = nan; is_inf = inf; is_zero = zero; inv = iv;
  endtask

  // One transfer with out_ready high; checks the registered output one cycle later.
  task automatic applyStimulus(input string tag, input logic s, input logic [7:0] e,
                               input logic [9:0] m, input logic c, input logic nx,
                               input logic [1:0] rm, input logic nan, input logic inf,
                               input logic zero, input logic iv,
                               input logic [15:0] exp_result, input logic [3:0] exp_flags);
    setOperand(s, e, m, c, nx, rm, nan, inf, zero, iv);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput({tag, "_valid"}, {15'h0, out_valid}, 16'h0001);
    checkOutput({tag, "_result"}, result, exp_result);
    checkOutput({tag, "_flags"}, {12'h0, flags}, {12'h0, exp_flags});
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef FMA16_STICKY_FLAGS_EN
    flag_clr  = 1'b0;
`endif
    setOperand(1'b0, 8'd0, 10'h000, 1'b0, 1'b0, RM_RNE, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_result", result, 16'h0000);
    checkOutput("rst_flags", {12'h0, flags}, 16'h0000);
    checkOutput("rst_valid", {15'h0, out_valid}, 16'h0000);
    checkOutput("rst_in_ready", {15'h0, in_ready}, 16'h0001);
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus("rne_norm", 1'b0, 8'd15, 10'h200, 1'b0, 1'b1, RM_RNE, 0, 0, 0, 0, 16'h3E00, 4'b0001);
    applyStimulus("carry", 1'b0, 8'd15, 10'h000, 1'b1, 1'b0, RM_RNE, 0, 0, 0, 0, 16'h4000, 4'b0000);
    applyStimulus("carry_ovf_rz", 1'b0, 8'd30, 10'h000, 1'b1, 1'b1, RM_RZ, 0, 0, 0, 0, 16'h7BFF, 4'b0101);
    applyStimulus("ovf_rne_neg", 1'b1, 8'd31, 10'h000, 1'b0, 1'b1, RM_RNE, 0, 0, 0, 0, 16'hFC00, 4'b0101);
    applyStimulus("ovf_rd_pos", 1'b0, 8'd31, 10'h000, 1'b0, 1'b1, RM_RD, 0, 0, 0, 0, 16'h7BFF, 4'b0101);
    applyStimulus("ovf_ru_pos", 1'b0, 8'd31, 10'h000, 1'b0, 1'b1, RM_RU, 0, 0, 0, 0, 16'h7C00, 4'b0101);
    applyStimulus("ovf_rd_neg", 1'b1, 8'd40, 10'h000, 1'b0, 1'b1, RM_RD, 0, 0, 0, 0, 16'hFC00, 4'b0101);
    applyStimulus("ovf_ru_neg", 1'b1, 8'd31, 10'h000, 1'b0, 1'b1, RM_RU, 0, 0, 0, 0, 16'hFBFF, 4'b0101);
    applyStimulus("inv_over_inf", 1'b0, 8'd15, 10'h000, 1'b0, 1'b0, RM_RNE, 0, 1, 0, 1, 16'h7E00, 4'b1000);
    applyStimulus("nan_quiet", 1'b1, 8'd15, 10'h000, 1'b0, 1'b1, RM_RNE, 1, 0, 0, 0, 16'h7E00, 4'b0000);
    applyStimulus("inf_neg", 1'b1, 8'd15, 10'h000, 1'b0, 1'b1, RM_RNE, 0, 1, 1, 0, 16'hFC00, 4'b0000);
    applyStimulus("zero_neg", 1'b1, 8'd15, 10'h000, 1'b0, 1'b1, RM_RNE, 0, 0, 1, 0, 16'h8000, 4'b0000);
    applyStimulus("unf_zero_exp", 1'b0, 8'd0, 10'h155, 1'b0, 1'b0, RM_RNE, 0, 0, 0, 0, 16'h0000, 4'b0011);
    applyStimulus("unf_neg_exp", 1'b1, 8'hFD, 10'h3FF, 1'b1, 1'b0, RM_RU, 0, 0, 0, 0, 16'h8000, 4'b0011);
    applyStimulus("max_normal", 1'b0, 8'd30, 10'h3FF, 1'b0, 1'b1, RM_RZ, 0, 0, 0, 0, 16'h7BFF, 4'b0001);
    applyStimulus("min_normal", 1'b1, 8'd1, 10'h000, 1'b0, 1'b0, RM_RNE, 0, 0, 0, 0, 16'h8400, 4'b0000);
    applyStimulus("carry_to_one", 1'b0, 8'hFF, 10'h000, 1'b1, 1'b1, RM_RNE, 0, 0, 0, 0, 16'h0000, 4'b0011);

    // Drain, then backpressure: A, B, C presented back to back while the sink stalls.
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("drain_valid", {15'h0, out_valid}, 16'h0000);
    out_ready = 1'b0;
    setOperand(1'b0, 8'd15, 10'h001, 1'b0, 1'b0, RM_RNE, 0, 0, 0, 0);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_a_result", result, 16'h3C01);
    checkOutput("bp_stall_in_ready", {15'h0, in_ready}, 16'h0000);
    setOperand(1'b0, 8'd16, 10'h002, 1'b0, 1'b0, RM_RNE, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_hold_result", result, 16'h3C01);
    checkOutput("bp_hold_valid", {15'h0, out_valid}, 16'h0001);
    checkOutput("bp_hold_in_ready", {15'h0, in_ready}, 16'h0000);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_b_result", result, 16'h4002);
    checkOutput("bp_b_valid", {15'h0, out_valid}, 16'h0001);
    setOperand(1'b1, 8'd17, 10'h003, 1'b0, 1'b1, RM_RNE, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_c_result", result, 16'hC403);
    checkOutput("bp_c_flags", {12'h0, flags}, 16'h0001);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_pop_valid", {15'h0, out_valid}, 16'h0000);

    // Asynchronous reset in the middle of the low phase must drop the held result.
    out_ready = 1'b0;
    setOperand(1'b0, 8'd20, 10'h0AA, 1'b0, 1'b0, RM_RNE, 0, 0, 0, 0);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("arst_pre_valid", {15'h0, out_valid}, 16'h0001);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_valid", {15'h0, out_valid}, 16'h0000);
    checkOutput("arst_result", result, 16'h0000);
    checkOutput("arst_in_ready", {15'h0, in_ready}, 16'h0001);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

`ifdef FMA16_STICKY_FLAGS_EN
    checkOutput("sticky_rst", {12'h0, sticky_flags}, 16'h0000);
    applyStimulus("sticky_ovf", 1'b0, 8'd31, 10'h000, 1'b0, 1'b0, RM_RZ, 0, 0, 0, 0, 16'h7BFF, 4'b0101);
    applyStimulus("sticky_norm", 1'b0, 8'd15, 10'h000, 1'b0, 1'b0, RM_RNE, 0, 0, 0, 0, 16'h3C00, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    checkOutput("sticky_accum", {12'h0, sticky_flags}, 16'h0005);
    applyStimulus("sticky_nx", 1'b0, 8'd15, 10'h000, 1'b0, 1'b1, RM_RNE, 0, 0, 0, 0, 16'h3C00, 4'b0001);
    flag_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flag_clr = 1'b0;
    checkOutput("sticky_clr_wins", {12'h0, sticky_flags}, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
